soundgen_mixer: RTL and testbench

Parametrised multi-voice square-wave sound generator with an integrated PWM DAC. NUM_CH independent tone channels each have a programmable half-period and volume. Channel amplitudes are summed and scaled to N bits, then converted to a single-bit PWM output. It replaces the fixed-duty single-DAC sound path inside the top-level soundgen wrapper and drives the audio pin.

---
 rtl/soundgen_pkg.sv | 19 +
 rtl/tone_channel.sv | 62 ++++++
 rtl/soundgen_mixer.sv | 110 +++++++++++
 tb/tb_soundgen_mixer.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/soundgen_pkg.sv
// soundgen_pkg: shared constants and width helpers for the
// multi-voice square-wave generator and its PWM mixer.
package soundgen_pkg;

   // Register select values carried on cfg_sel
   localparam logic CFG_PERIOD = 1'b0;
   localparam logic CFG_VOLUME = 1'b1;

   // Width of the channel sum: one extra bit per doubling of channels
   function automatic int sum_width(input int n, input int num_ch);
      return n + $clog2(num_ch);
   endfunction

   // Width of the channel index, never narrower than one bit
   function automatic int ch_width(input int num_ch);
      return (num_ch > 1) ? $clog2(num_ch) : 1;
   endfunction

endpackage

// File: rtl/tone_channel.sv
// tone_channel: one square-wave voice with programmable half-period
// and volume; outputs its current amplitude contribution.
module tone_channel
   import soundgen_pkg::*;
#(
   parameter int N     = 8,
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             wr_period,
   input  logic             wr_volume,
   input  logic [DIV_W-1:0] period_data,
   input  logic [N-1:0]     volume_data,
   output logic [N-1:0]     amp,
   output logic             square
);

   logic [DIV_W-1:0] period;
   logic [DIV_W-1:0] divider;
   logic [N-1:0]     volume;

   // Volume register; takes effect whenever the mixer next samples
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         volume <= '0;
      end else if (wr_volume) begin
         volume <= volume_data;
      end
   end

   // Period register and divider; a period write restarts the phase
   // and overrides any reload happening on the same edge
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         period  <= '0;
         divider <= '0;
         square  <= 1'b0;
      end else if (wr_period) begin
         period  <= period_data;
         divider <= period_data;
         square  <= 1'b0;
      end else if (en) begin
         if (period == '0) begin
            divider <= '0;
            square  <= 1'b0;
         end else if (divider == '0) begin
            divider <= period;
            square  <= ~square;
         end else begin
            divider <= divider - 1'b1;
         end
      end
   end

   // Amplitude is the volume while the square is high
   always_comb begin
      amp = square ? volume : '0;
   end

endmodule

// File: rtl/soundgen_mixer.sv
// soundgen_mixer: NUM_CH square-wave voices summed, scaled to N bits
// and played out through a registered single-bit PWM DAC.
module soundgen_mixer
   import soundgen_pkg::*;
#(
   parameter int N      = 8,
   parameter int NUM_CH = 4,
   parameter int DIV_W  = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        en,
   input  logic                        cfg_we,
   input  logic [ch_width(NUM_CH)-1:0] cfg_ch,
   input  logic                        cfg_sel,
   input  logic [DIV_W-1:0]            cfg_data,
   output logic                        pwm_out,
   output logic                        frame_strobe,
   output logic [NUM_CH-1:0]           tone_out
);

   localparam int SHIFT = $clog2(NUM_CH);
   localparam int SW    = sum_width(N, NUM_CH);

   logic [NUM_CH-1:0] wr_period;
   logic [NUM_CH-1:0] wr_volume;
   logic [NUM_CH-1:0] square;
   logic [N-1:0]      amp [NUM_CH];
   logic [SW-1:0]     sum;
   logic [N-1:0]      sample;
   logic [N-1:0]      duty;
   logic [N-1:0]      pwm_cnt;

   // Steer the config strobe to one channel; out-of-range indices
   // match no channel and are dropped
   always_comb begin
      wr_period = '0;
      wr_volume = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (cfg_we && (int'(cfg_ch) == i)) begin
            wr_period[i] = (cfg_sel == CFG_PERIOD);
            wr_volume[i] = (cfg_sel == CFG_VOLUME);
         end
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      tone_channel #(
         .N     (N),
         .DIV_W (DIV_W)
      ) u_ch (
         .clk         (clk),
         .reset       (reset),
         .en          (en),
         .wr_period   (wr_period[g]),
         .wr_volume   (wr_volume[g]),
         .period_data (cfg_data),
         .volume_data (cfg_data[N-1:0]),
         .amp         (amp[g]),
         .square      (square[g])
      );
   end

   // Sum all channel amplitudes at full width; cannot overflow
   always_comb begin
      sum = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         sum = sum + SW'(amp[i]);
      end
   end

   // Scaled mix, re-registered every clock
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sample <= '0;
      end else begin
         sample <= N'(sum >> SHIFT);
      end
   end

   // Frame counter and once-per-frame duty latch, frozen while disabled
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pwm_cnt <= '0;
         duty    <= '0;
      end else if (en) begin
         pwm_cnt <= pwm_cnt + 1'b1;
         if (pwm_cnt == {N{1'b1}}) begin
            duty <= sample;
         end
      end
   end

   // Registered PWM and frame marker, forced low while disabled
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pwm_out      <= 1'b0;
         frame_strobe <= 1'b0;
      end else if (en) begin
         pwm_out      <= (pwm_cnt < duty);
         frame_strobe <= (pwm_cnt == '0);
      end else begin
         pwm_out      <= 1'b0;
         frame_strobe <= 1'b0;
      end
   end

   assign tone_out = square;

endmodule

// File: tb/tb_soundgen_mixer.sv
// tb_soundgen_mixer: randomized and directed checks of soundgen_mixer
// against an arithmetic reference model of the tone and PWM rules.
module tb_soundgen_mixer;

   localparam int NCH = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        en = 1'b0;
   logic        cfg_we = 1'b0;
   logic [1:0]  cfg_ch = '0;
   logic        cfg_sel = 1'b0;
   logic [15:0] cfg_data = '0;
   logic        pwm_out;
   logic        frame_strobe;
   logic [3:0]  tone_out;

   int checks = 0;
   int failures = 0;

   soundgen_mixer #(.N(8), .NUM_CH(NCH), .DIV_W(16)) dut (
      .clk          (clk),
      .reset        (reset),
      .en           (en),
      .cfg_we       (cfg_we),
      .cfg_ch       (cfg_ch),
      .cfg_sel      (cfg_sel),
      .cfg_data     (cfg_data),
      .pwm_out      (pwm_out),
      .frame_strobe (frame_strobe),
      .tone_out     (tone_out)
   );

   always #5 clk = ~clk;

   // Reference model: per channel period, volume and number of enabled
   // clocks since the last period write; square follows from division.
   int m_p [NCH];
   int m_v [NCH];
   int m_j [NCH];
   int m_cnt, m_duty, m_sample;
   bit m_pwm, m_fs;

   function automatic bit m_sq(input int c);
      return (m_p[c] != 0) && (((m_j[c] / (m_p[c] + 1)) % 2) == 1);
   endfunction

   function automatic int m_sum();
      int s = 0;
      for (int c = 0; c < NCH; c++) if (m_sq(c)) s += m_v[c];
      return s;
   endfunction

   function automatic logic [3:0] m_tone();
      logic [3:0] t;
      for (int c = 0; c < NCH; c++) t[c] = m_sq(c);
      return t;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int c = 0; c < NCH; c++) begin
            m_p[c] <= 0;
            m_v[c] <= 0;
            m_j[c] <= 0;
         end
         m_cnt <= 0;
         m_duty <= 0;
         m_sample <= 0;
         m_pwm <= 0;
         m_fs <= 0;
      end else begin
         m_sample <= m_sum() / NCH;
         if (en) begin
            m_pwm <= (m_cnt < m_duty);
            m_fs <= (m_cnt == 0);
            if (m_cnt == 255) m_duty <= m_sample;
            m_cnt <= (m_cnt + 1) % 256;
            for (int c = 0; c < NCH; c++) m_j[c] <= m_j[c] + 1;
         end else begin
            m_pwm <= 0;
            m_fs <= 0;
         end
         if (cfg_we) begin
            if (cfg_sel == 1'b0) begin
               m_p[cfg_ch] <= int'(cfg_data);
               m_j[cfg_ch] <= 0;
            end else begin
               m_v[cfg_ch] <= int'(cfg_data) % 256;
            end
         end
      end
   end

   task automatic do_reset();
      cfg_we = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic cfg(input int ch, input bit sel, input int data);
      cfg_we = 1'b1;
      cfg_ch = 2'(ch);
      cfg_sel = sel;
      cfg_data = 16'(data);
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   task automatic wait_tone(input logic [3:0] mask, input logic [3:0] val,
                            input int limit, output bit ok);
      int n = 0;
      while (((tone_out & mask) !== val) && n < limit) begin
         @(negedge clk);
         n++;
      end
      ok = (n < limit);
   endtask

   task automatic wait_strobes(input int k, output bit ok);
      ok = 1'b1;
      for (int s = 0; s < k; s++) begin
         int n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (frame_strobe !== 1'b1 && n < 600);
         if (frame_strobe !== 1'b1) ok = 1'b0;
      end
   endtask

   task automatic test_reset();
      logic [5:0] got;
      #2;
      got = {pwm_out, frame_strobe, tone_out};
      checks++;
      if (got !== 6'b0) begin
         failures++;
         $display("FAIL reset_hold got %b want 000000", got);
      end
      @(negedge clk);
      reset = 1'b0;
      cfg(0, 1'b0, 3);
      cfg(0, 1'b1, 255);
      en = 1'b1;
      repeat (300 + $urandom_range(0, 100)) begin
         @(negedge clk);
         checks++;
         if ({pwm_out, frame_strobe, tone_out} !== {m_pwm, m_fs, m_tone()}) begin
            failures++;
            $display("FAIL reset_run t=%0t got %b want %b", $time,
                     {pwm_out, frame_strobe, tone_out}, {m_pwm, m_fs, m_tone()});
         end
      end
      #2;
      reset = 1'b1;
      #1;
      got = {pwm_out, frame_strobe, tone_out};
      checks++;
      if (got !== 6'b0) begin
         failures++;
         $display("FAIL reset_async got %b want 000000", got);
      end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (frame_strobe !== 1'b1) begin
         failures++;
         $display("FAIL first_strobe got %b want 1", frame_strobe);
      end
      repeat (20) begin
         @(negedge clk);
         checks++;
         if ({pwm_out, frame_strobe, tone_out} !== {m_pwm, m_fs, m_tone()}) begin
            failures++;
            $display("FAIL reset_after t=%0t got %b want %b", $time,
                     {pwm_out, frame_strobe, tone_out}, {m_pwm, m_fs, m_tone()});
         end
      end
   endtask

   task automatic test_tone();
      do_reset();
      en = 1'b1;
      cfg(0, 1'b0, 3);
      for (int j = 0; j <= 13; j++) begin
         if (j > 0) @(negedge clk);
         checks++;
         if (tone_out[0] !== 1'((j / 4) % 2)) begin
            failures++;
            $display("FAIL tone_p3 j=%0d got %b want %0d", j, tone_out[0], (j / 4) % 2);
         end
      end
      cfg(0, 1'b0, 1);
      for (int j = 0; j <= 12; j++) begin
         if (j > 0) @(negedge clk);
         checks++;
         if (tone_out[0] !== 1'((j / 2) % 2)) begin
            failures++;
            $display("FAIL tone_p1 j=%0d got %b want %0d", j, tone_out[0], (j / 2) % 2);
         end
         checks++;
         if ({pwm_out, frame_strobe, tone_out} !== {m_pwm, m_fs, m_tone()}) begin
            failures++;
            $display("FAIL tone_model t=%0t got %b want %b", $time,
                     {pwm_out, frame_strobe, tone_out}, {m_pwm, m_fs, m_tone()});
         end
      end
   endtask

   task automatic test_volume();
      bit ok;
      int hi = 0;
      do_reset();
      en = 1'b1;
      cfg(0, 1'b0, 1000);
      cfg(0, 1'b1, 255);
      wait_tone(4'b0001, 4'b0001, 2000, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL vol_tone_wait got timeout want tone high");
      end
      wait_strobes(2, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL vol_strobe_wait got timeout want strobe");
      end
      for (int i = 0; i < 256; i++) begin
         if (i > 0) @(negedge clk);
         hi += int'(pwm_out);
         checks++;
         if ({pwm_out, frame_strobe, tone_out} !== {m_pwm, m_fs, m_tone()}) begin
            failures++;
            $display("FAIL vol_model t=%0t got %b want %b", $time,
                     {pwm_out, frame_strobe, tone_out}, {m_pwm, m_fs, m_tone()});
         end
      end
      checks++;
      if (hi !== 63) begin
         failures++;
         $display("FAIL vol_duty got %0d want 63", hi);
      end
   endtask

   task automatic test_all_channels();
      bit ok;
      int hi;
      do_reset();
      en = 1'b0;
      for (int c = 0; c < NCH; c++) begin
         cfg(c, 1'b0, 1000);
         cfg(c, 1'b1, 255);
      end
      en = 1'b1;
      for (int phase = 0; phase < 2; phase++) begin
         wait_tone(4'hf, (phase == 0) ? 4'hf : 4'h0, 1100, ok);
         checks++;
         if (!ok) begin
            failures++;
            $display("FAIL all_tone_wait phase=%0d got timeout want tones", phase);
         end
         wait_strobes(2, ok);
         checks++;
         if (!ok) begin
            failures++;
            $display("FAIL all_strobe_wait got timeout want strobe");
         end
         hi = 0;
         for (int i = 0; i < 256; i++) begin
            if (i > 0) @(negedge clk);
            hi += int'(pwm_out);
            checks++;
            if ({pwm_out, frame_strobe, tone_out} !== {m_pwm, m_fs, m_tone()}) begin
               failures++;
               $display("FAIL all_model t=%0t got %b want %b", $time,
                        {pwm_out, frame_strobe, tone_out}, {m_pwm, m_fs, m_tone()});
            end
         end
         checks++;
         if (hi !== ((phase == 0) ? 255 : 0)) begin
            failures++;
            $display("FAIL all_duty phase=%0d got %0d want %0d", phase, hi,
                     (phase == 0) ? 255 : 0);
         end
      end
   endtask

   task automatic test_mute();
      do_reset();
      en = 1'b1;
      cfg(2, 1'b0, 0);
      cfg(2, 1'b1, 200);
      cfg(0, 1'b0, $urandom_range(1, 40));
      cfg(0, 1'b1, $urandom_range(0, 255));
      cfg(1, 1'b0, $urandom_range(1, 40));
      cfg(1, 1'b1, $urandom_range(0, 255));
      repeat (600) begin
         @(negedge clk);
         checks++;
         if (tone_out[2] !== 1'b0) begin
            failures++;
            $display("FAIL mute_tone got %b want 0", tone_out[2]);
         end
         checks++;
         if ({pwm_out, frame_strobe, tone_out} !== {m_pwm, m_fs, m_tone()}) begin
            failures++;
            $display("FAIL mute_model t=%0t got %b want %b", $time,
                     {pwm_out, frame_strobe, tone_out}, {m_pwm, m_fs, m_tone()});
         end
         if ($urandom_range(0, 15) == 0) begin
            cfg_we = 1'b1;
            cfg_ch = 2'($urandom_range(0, 1));
            cfg_sel = 1'($urandom_range(0, 1));
            cfg_data = 16'($urandom_range(1, 60));
         end else begin
            cfg_we = 1'b0;
         end
      end
      cfg_we = 1'b0;
   endtask

   task automatic test_enable();
      bit ok;
      int hi = 0;
      logic [3:0] frozen = '0;
      do_reset();
      en = 1'b1;
      cfg(1, 1'b0, 1000);
      cfg(1, 1'b1, 128);
      wait_tone(4'b0010, 4'b0010, 2000, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL en_tone_wait got timeout want tone high");
      end
      wait_strobes(2, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL en_strobe_wait got timeout want strobe");
      end
      for (int i = 0; i < 266; i++) begin
         if (i > 0) @(negedge clk);
         checks++;
         if ({pwm_out, frame_strobe, tone_out} !== {m_pwm, m_fs, m_tone()}) begin
            failures++;
            $display("FAIL en_model t=%0t got %b want %b", $time,
                     {pwm_out, frame_strobe, tone_out}, {m_pwm, m_fs, m_tone()});
         end
         if (i >= 101 && i <= 110) begin
            checks++;
            if ({pwm_out, frame_strobe, tone_out} !== {2'b00, frozen}) begin
               failures++;
               $display("FAIL en_paused i=%0d got %b want %b", i,
                        {pwm_out, frame_strobe, tone_out}, {2'b00, frozen});
            end
         end else begin
            hi += int'(pwm_out);
         end
         if (i == 100) begin
            frozen = tone_out;
            en = 1'b0;
         end
         if (i == 110) en = 1'b1;
      end
      checks++;
      if (hi !== 32) begin
         failures++;
         $display("FAIL en_duty got %0d want 32", hi);
      end
      @(negedge clk);
      checks++;
      if (frame_strobe !== 1'b1) begin
         failures++;
         $display("FAIL en_frame_len got %b want 1", frame_strobe);
      end
   endtask

   initial begin
      test_reset();
      test_tone();
      test_volume();
      test_all_channels();
      test_mute();
      test_enable();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
